// File: rtl/aes_pkg.sv
// Shared definitions for the AES display path.
// Holds the block size, byte-index width, scan FSM state encodings, the
// default dwell for the board clock and a byte-select helper.
package aes_pkg;

   localparam int AES_BLOCK_BYTES   = 16;
   localparam int AES_IDX_W         = 4;
   localparam int AES_DWELL_DEFAULT = 50000000;

   typedef logic [1:0] scan_state_t;

   localparam scan_state_t SCAN_IDLE = 2'd0;
   localparam scan_state_t SCAN_SHOW = 2'd1;
   localparam scan_state_t SCAN_DONE = 2'd2;

   // Byte idx of a block in FIPS-197 order: byte 0 is bits [127:120].
   function automatic logic [7:0] block_byte(input logic [127:0] blk,
                                             input logic [AES_IDX_W-1:0] idx);
      logic [127:0] shifted;
      shifted = blk << {idx, 3'b000};
      return shifted[127:120];
   endfunction

endpackage

// File: rtl/aes_byte_scanner_if.sv
// Handshake/data bundle between the AES top (master) and the byte scanner
// (slave).
//   load, block_in, step, auto_en      : master -> scanner
//   byte_out, byte_idx, byte_valid,
//   busy, done                         : scanner -> master / display
interface aes_byte_scanner_if;
   import aes_pkg::*;

   logic                 load;
   logic [127:0]         block_in;
   logic                 step;
   logic                 auto_en;
   logic [7:0]           byte_out;
   logic [AES_IDX_W-1:0] byte_idx;
   logic                 byte_valid;
   logic                 busy;
   logic                 done;

   modport master (
      output load, block_in, step, auto_en,
      input  byte_out, byte_idx, byte_valid, busy, done
   );

   modport slave (
      input  load, block_in, step, auto_en,
      output byte_out, byte_idx, byte_valid, busy, done
   );

endinterface

// File: rtl/aes_byte_scanner_dwell_timer.sv
// Dwell counter for the byte scanner.
//   clk, reset_n : clock and async active-low reset
//   run          : count one cycle
//   clear        : return the count to zero (wins over run)
//   expire       : registered flag, high while count == DWELL-1
module scan_dwell_timer #(
   parameter int DWELL   = 50000000,
   parameter int DWELL_W = 26
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

   logic [DWELL_W-1:0] count_r;
   logic [DWELL_W-1:0] count_next_s;

   // Next count: clear has priority, otherwise count while running, else hold.
   always_comb begin
      count_next_s = count_r;
      if (clear) begin
         count_next_s = {DWELL_W{1'b0}};
      end else if (run) begin
         count_next_s = count_r + DWELL_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Count register; expire is precomputed from the next value so it is a
   // flop that still matches the current count exactly (DWELL=1 keeps it high).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {DWELL_W{1'b0}};
         expire  <= (LAST == {DWELL_W{1'b0}});
      end else begin
         count_r <= count_next_s;
         expire  <= (count_next_s == LAST);
      end
   end

endmodule

// File: rtl/aes_byte_scanner.sv
// Captures one 128-bit AES block and presents it a byte at a time, with its
// index, to the seven-segment encoder. Bytes advance on a manual step pulse
// or when the dwell timer expires with auto_en set.
//   clk, reset_n : clock and async active-low reset
//   bus (slave)  : load/block_in/step/auto_en in;
//                  byte_out/byte_idx/byte_valid/busy/done out (all registered)
module aes_byte_scanner
   import aes_pkg::*;
#(
   parameter int DWELL   = AES_DWELL_DEFAULT,
   parameter int DWELL_W = 26
) (
   input  logic                clk,
   input  logic                reset_n,
   aes_byte_scanner_if.slave   bus
);

   localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(AES_BLOCK_BYTES - 1);

   scan_state_t          state_r;
   logic [127:0]         block_r;
   logic [AES_IDX_W-1:0] idx_r;
   logic [7:0]           byte_r;
   logic                 valid_r;
   logic                 busy_r;
   logic                 done_r;

   logic                 show_s;
   logic                 expire_s;
   logic                 advance_s;
   logic                 run_s;
   logic                 clear_s;

   // Advance decode: step and timer expiry together are a single advance.
   always_comb begin
      show_s    = (state_r == SCAN_SHOW);
      advance_s = show_s & (bus.step | (bus.auto_en & expire_s));
      run_s     = show_s & bus.auto_en & ~advance_s & ~bus.load;
      clear_s   = bus.load | advance_s;
   end

   scan_dwell_timer #(
      .DWELL   (DWELL),
      .DWELL_W (DWELL_W)
   ) u_dwell (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run_s),
      .clear   (clear_s),
      .expire  (expire_s)
   );

   // Scan FSM, captured block, index and registered outputs; load always wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= SCAN_IDLE;
         block_r <= 128'd0;
         idx_r   <= {AES_IDX_W{1'b0}};
         byte_r  <= 8'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (bus.load) begin
         state_r <= SCAN_SHOW;
         block_r <= bus.block_in;
         idx_r   <= {AES_IDX_W{1'b0}};
         byte_r  <= bus.block_in[127:120];
         valid_r <= 1'b1;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else if (advance_s) begin
         if (idx_r != LAST_IDX) begin
            idx_r  <= idx_r + AES_IDX_W'(1);
            byte_r <= block_byte(block_r, idx_r + AES_IDX_W'(1));
         end else begin
            // Last byte stays on the display with its index.
            state_r <= SCAN_DONE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
         end
      end else begin
         state_r <= state_r;
      end
   end

   assign bus.byte_out   = byte_r;
   assign bus.byte_idx   = idx_r;
   assign bus.byte_valid = valid_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_aes_byte_scanner.sv
module tb_aes_byte_scanner;

   typedef struct {
      logic [7:0] b;
      logic [3:0] idx;
   } vec_t;

   localparam logic [127:0] B1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B3 = 128'hffeeddccbbaa99887766554433221100;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   vec_t tbl [16];

   aes_byte_scanner_if bus ();

   aes_byte_scanner #(
      .DWELL   (4),
      .DWELL_W (26)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compares {byte_out, byte_idx, byte_valid, busy, done} in one go.
   task automatic chk_out(input string name, input logic [7:0] b, input logic [3:0] i,
                          input logic v, input logic bs, input logic d);
      check(name,
            {17'd0, bus.byte_out, bus.byte_idx, bus.byte_valid, bus.busy, bus.done},
            {17'd0, b, i, v, bs, d});
   endtask

   task automatic step_pulse();
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic do_load(input logic [127:0] blk, input logic auto);
      bus.load     = 1'b1;
      bus.block_in = blk;
      bus.auto_en  = auto;
      cyc();
      bus.load     = 1'b0;
      bus.block_in = ~blk;
   endtask

   initial begin
      int n;
      n_tests = 0;
      n_fail  = 0;

      tbl[0]  = '{8'h69, 4'd0};  tbl[1]  = '{8'hc4, 4'd1};
      tbl[2]  = '{8'he0, 4'd2};  tbl[3]  = '{8'hd8, 4'd3};
      tbl[4]  = '{8'h6a, 4'd4};  tbl[5]  = '{8'h7b, 4'd5};
      tbl[6]  = '{8'h04, 4'd6};  tbl[7]  = '{8'h30, 4'd7};
      tbl[8]  = '{8'hd8, 4'd8};  tbl[9]  = '{8'hcd, 4'd9};
      tbl[10] = '{8'hb7, 4'd10}; tbl[11] = '{8'h80, 4'd11};
      tbl[12] = '{8'h70, 4'd12}; tbl[13] = '{8'hb4, 4'd13};
      tbl[14] = '{8'hc5, 4'd14}; tbl[15] = '{8'h5a, 4'd15};

      reset_n      = 1'b0;
      bus.load     = 1'b0;
      bus.block_in = 128'd0;
      bus.step     = 1'b0;
      bus.auto_en  = 1'b0;
      cyc();
      cyc();
      chk_out("reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      bus.step = 1'b1;
      bus.auto_en = 1'b1;
      cyc();
      cyc();
      bus.step = 1'b0;
      bus.auto_en = 1'b0;
      chk_out("idle_ignores", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

      // Load with auto off: first byte after one cycle, then held.
      do_load(B1, 1'b0);
      chk_out("load_first", 8'h69, 4'd0, 1'b1, 1'b1, 1'b0);
      repeat (100) cyc();
      chk_out("hold_100", 8'h69, 4'd0, 1'b1, 1'b1, 1'b0);

      // Manual stepping through the table.
      for (int i = 0; i < 16; i++) begin
         chk_out($sformatf("step_%0d", i), tbl[i].b, tbl[i].idx, 1'b1, 1'b1, 1'b0);
         step_pulse();
      end
      chk_out("step_done", 8'h5a, 4'd15, 1'b0, 1'b0, 1'b1);
      step_pulse();
      bus.auto_en = 1'b1;
      repeat (10) cyc();
      bus.auto_en = 1'b0;
      chk_out("done_ignores", 8'h5a, 4'd15, 1'b0, 1'b0, 1'b1);

      // Auto mode, DWELL=4, with a 10-cycle pause at idx 5, dwell 2.
      do_load(B2, 1'b1);
      for (int k = 0; k < 16; k++) begin
         chk_out($sformatf("auto_%0d", k), 8'(k * 17), 4'(k), 1'b1, 1'b1, 1'b0);
         if (k == 5) begin
            cyc();
            cyc();
            bus.auto_en = 1'b0;
            repeat (10) cyc();
            chk_out("pause_frozen", 8'h55, 4'd5, 1'b1, 1'b1, 1'b0);
            bus.auto_en = 1'b1;
            cyc();
            chk_out("resume_1", 8'h55, 4'd5, 1'b1, 1'b1, 1'b0);
            cyc();
         end else begin
            repeat (4) cyc();
         end
      end
      chk_out("auto_done", 8'hff, 4'd15, 1'b0, 1'b0, 1'b1);

      // Done rises exactly 64 cycles after the load edge.
      do_load(B2, 1'b1);
      n = 0;
      while (!bus.done && n < 200) begin
         cyc();
         n++;
      end
      check("done_latency", 32'(n), 32'd64);

      // Step coinciding with timer expiry counts once.
      do_load(B2, 1'b1);
      repeat (12) cyc();
      chk_out("pre_expiry", 8'h33, 4'd3, 1'b1, 1'b1, 1'b0);
      repeat (3) cyc();
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      chk_out("step_and_expire", 8'h44, 4'd4, 1'b1, 1'b1, 1'b0);
      repeat (3) cyc();
      chk_out("restart_dwell", 8'h44, 4'd4, 1'b1, 1'b1, 1'b0);
      cyc();
      chk_out("next_auto", 8'h55, 4'd5, 1'b1, 1'b1, 1'b0);

      // Load together with step mid-scan at idx 9.
      do_load(B1, 1'b0);
      repeat (9) step_pulse();
      chk_out("at_idx9", 8'hcd, 4'd9, 1'b1, 1'b1, 1'b0);
      bus.load     = 1'b1;
      bus.block_in = B3;
      bus.step     = 1'b1;
      cyc();
      bus.load     = 1'b0;
      bus.step     = 1'b0;
      bus.block_in = 128'd0;
      chk_out("load_wins", 8'hff, 4'd0, 1'b1, 1'b1, 1'b0);
      step_pulse();
      chk_out("after_reload", 8'hee, 4'd1, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset mid-scan at idx 7.
      repeat (6) step_pulse();
      chk_out("at_idx7", 8'h88, 4'd7, 1'b1, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("async_reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc();
      reset_n = 1'b1;
      bus.auto_en = 1'b1;
      step_pulse();
      repeat (8) cyc();
      chk_out("post_reset_idle", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      do_load(B2, 1'b0);
      chk_out("post_reset_load", 8'h00, 4'd0, 1'b1, 1'b1, 1'b0);
      step_pulse();
      chk_out("post_reset_step", 8'h11, 4'd1, 1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
